// File: rtl/lock_key_loader_pkg.sv
// rtl/lock_key_loader_pkg.sv - shared constants and state type for the c499 key loader
package lock_key_pkg;

  localparam int KEY_W   = 34;
  localparam int NBYTES  = 5;
  localparam int P_LSB   = 0;
  localparam int X_LSB   = 4;
  localparam int P_W     = X_LSB - P_LSB;
  localparam int X_W     = KEY_W - X_LSB;
  localparam int TIMEOUT = 255;
  localparam logic [7:0] CSUM_SEED = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    ARMED,
    ERROR
  } state_t;

endpackage

// File: rtl/lock_key_loader_if.sv
// rtl/lock_key_loader_if.sv - key byte stream from the secure key store
interface lock_key_loader_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/lock_key_loader_csum.sv
// rtl/lock_key_loader_csum.sv - running XOR over key bytes and checksum
module lock_key_csum
  import lock_key_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       seed,
  input  logic       acc_en,
  input  logic [7:0] acc_data,
  output logic       match
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (seed) begin
      sum_d = CSUM_SEED;
    end else if (acc_en) begin
      sum_d = sum_q ^ acc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  // The checksum byte is folded in too, so a clean load leaves zero behind.
  assign match = (sum_q == 8'h00);

endmodule

// File: rtl/lock_key_loader.sv
// rtl/lock_key_loader.sv - receives, verifies and commits the c499 unlock key
module lock_key_loader
  import lock_key_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  lock_key_loader_if.slave    s,
  output logic [P_W-1:0]      key_p,
  output logic [X_W-1:0]      key_x,
  output logic                key_valid,
  output logic                key_err,
  output logic                busy
);

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   staging_q, staging_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [7:0]         tmo_q, tmo_d;
  logic               resv_bad_q, resv_bad_d;
  logic [P_W-1:0]     key_p_q, key_p_d;
  logic [X_W-1:0]     key_x_q, key_x_d;
  logic               key_valid_q, key_valid_d;
  logic               key_err_q, key_err_d;

  logic in_ready;
  logic beat;
  logic csum_seed;
  logic csum_acc;
  logic csum_match;

  assign in_ready   = (state_q == LOAD);
  assign beat       = s.in_valid & in_ready;
  assign s.in_ready = in_ready;

  lock_key_csum u_csum (
    .clk      (clk),
    .rst      (rst),
    .seed     (csum_seed),
    .acc_en   (csum_acc),
    .acc_data (s.in_data),
    .match    (csum_match)
  );

  always_comb begin
    state_d     = state_q;
    staging_d   = staging_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    resv_bad_d  = resv_bad_q;
    key_p_d     = key_p_q;
    key_x_d     = key_x_q;
    key_valid_d = key_valid_q;
    key_err_d   = key_err_q;
    csum_seed   = 1'b0;
    csum_acc    = 1'b0;

    case (state_q)
      IDLE, ARMED, ERROR: begin
        if (load_start) begin
          // Old key stays on the outputs until the next commit.
          state_d     = LOAD;
          staging_d   = '0;
          cnt_d       = 3'd0;
          tmo_d       = 8'd0;
          resv_bad_d  = 1'b0;
          key_valid_d = 1'b0;
          key_err_d   = 1'b0;
          csum_seed   = 1'b1;
        end
      end
      LOAD: begin
        if (beat) begin
          tmo_d    = 8'd0;
          csum_acc = 1'b1;
          cnt_d    = cnt_q + 3'd1;
          case (cnt_q)
            3'd0: staging_d[7:0]   = s.in_data;
            3'd1: staging_d[15:8]  = s.in_data;
            3'd2: staging_d[23:16] = s.in_data;
            3'd3: staging_d[31:24] = s.in_data;
            3'd4: begin
              staging_d[33:32] = s.in_data[1:0];
              resv_bad_d       = |s.in_data[7:2];
            end
            default: state_d = CHECK;
          endcase
        end else if (tmo_q == 8'(TIMEOUT - 1)) begin
          state_d     = ERROR;
          key_p_d     = '0;
          key_x_d     = '0;
          key_valid_d = 1'b0;
          key_err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      CHECK: begin
        if (csum_match && !resv_bad_q) begin
          state_d     = ARMED;
          key_p_d     = staging_q[X_LSB-1:P_LSB];
          key_x_d     = staging_q[KEY_W-1:X_LSB];
          key_valid_d = 1'b1;
          key_err_d   = 1'b0;
        end else begin
          state_d     = ERROR;
          key_p_d     = '0;
          key_x_d     = '0;
          key_valid_d = 1'b0;
          key_err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      staging_q   <= '0;
      cnt_q       <= 3'd0;
      tmo_q       <= 8'd0;
      resv_bad_q  <= 1'b0;
      key_p_q     <= '0;
      key_x_q     <= '0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      staging_q   <= staging_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      resv_bad_q  <= resv_bad_d;
      key_p_q     <= key_p_d;
      key_x_q     <= key_x_d;
      key_valid_q <= key_valid_d;
      key_err_q   <= key_err_d;
    end
  end

  assign key_p     = key_p_q;
  assign key_x     = key_x_q;
  assign key_valid = key_valid_q;
  assign key_err   = key_err_q;
  assign busy      = (state_q == LOAD) || (state_q == CHECK);

endmodule

// File: tb/tb_lock_key_loader.sv
// tb/tb_lock_key_loader.sv - self-checking bench for lock_key_loader
module tb_lock_key_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [3:0]  key_p;
  logic [29:0] key_x;
  logic        key_valid;
  logic        key_err;
  logic        busy;

  lock_key_loader_if bus ();

  lock_key_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .s          (bus),
    .key_p      (key_p),
    .key_x      (key_x),
    .key_valid  (key_valid),
    .key_err    (key_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  kb [0:5];
  logic [3:0]  exp_p;
  logic [29:0] exp_x;
  logic        exp_ok;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] b, input bit ls);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    load_start   = ls;
    tick();
    bus.in_valid = 1'b0;
    load_start   = 1'b0;
  endtask

  task automatic feed(input int first, input int last, input int gapmax, input bit toggle, input bit noise);
    for (int i = first; i <= last; i++) begin
      int gap;
      gap = toggle ? 1 : $urandom_range(0, gapmax);
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        load_start   = noise && ($urandom_range(0, 3) == 0);
        tick();
      end
      send_beat(kb[i], noise && ($urandom_range(0, 2) == 0));
    end
  endtask

  // Checksum is the seed XORed with the five key bytes.
  task automatic fill_csum();
    kb[5] = 8'hA5 ^ kb[0] ^ kb[1] ^ kb[2] ^ kb[3] ^ kb[4];
  endtask

  // Reference: decide the outcome of a load from the byte list alone.
  task automatic model_load();
    logic [33:0] key;
    logic [7:0]  x;
    x = 8'hA5;
    for (int i = 0; i < 5; i++) x = x ^ kb[i];
    key    = {kb[4][1:0], kb[3], kb[2], kb[1], kb[0]};
    exp_ok = (x == kb[5]) && (kb[4][7:2] == 6'd0);
    exp_p  = exp_ok ? key[3:0]  : 4'h0;
    exp_x  = exp_ok ? key[33:4] : 30'h0;
  endtask

  task automatic set_bytes(input logic [39:0] v, input logic [7:0] cs);
    for (int i = 0; i < 5; i++) kb[i] = v[8*i +: 8];
    kb[5] = cs;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({key_p, key_x, key_valid, key_err, busy, bus.in_ready} !== 38'h0) begin
      bad++;
      $display("FAIL reset outputs got=%h exp=0", {key_p, key_x, key_valid, key_err, busy, bus.in_ready});
    end
  endtask

  task automatic test_good_load();
    set_bytes({8'h02, 8'h78, 8'h56, 8'h34, 8'h12}, 8'hAF);
    start_load();
    total++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL good_enter_load busy=%b in_ready=%b exp 1 1", busy, bus.in_ready);
    end
    feed(0, 5, 0, 0, 0);
    total++;
    if (key_valid !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL good_check_cycle valid=%b busy=%b rdy=%b exp 0 1 0", key_valid, busy, bus.in_ready);
    end
    tick();
    total++;
    if (key_valid !== 1'b1 || key_err !== 1'b0 || key_p !== 4'h2 || key_x !== 30'h27856341 || busy !== 1'b0) begin
      bad++;
      $display("FAIL good_commit got v=%b e=%b p=%h x=%h busy=%b exp 1 0 2 27856341 0",
               key_valid, key_err, key_p, key_x, busy);
    end
  endtask

  task automatic test_bad_checksum();
    set_bytes({8'h02, 8'h78, 8'h56, 8'h34, 8'h12}, 8'hAE);
    start_load();
    feed(0, 5, 2, 0, 0);
    tick();
    total++;
    if (key_err !== 1'b1 || key_valid !== 1'b0 || key_p !== 4'h0 || key_x !== 30'h0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bad_csum got e=%b v=%b p=%h x=%h exp 1 0 0 0", key_err, key_valid, key_p, key_x);
    end
  endtask

  task automatic test_reserved();
    set_bytes({8'h06, 8'h78, 8'h56, 8'h34, 8'h12}, 8'hAB);
    start_load();
    total++;
    if (key_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear_on_start got=%b exp=0", key_err);
    end
    feed(0, 5, 1, 0, 0);
    tick();
    total++;
    if (key_err !== 1'b1 || key_valid !== 1'b0 || key_p !== 4'h0) begin
      bad++;
      $display("FAIL reserved_bits got e=%b v=%b p=%h exp 1 0 0", key_err, key_valid, key_p);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 6; i++) kb[i] = 8'($urandom);
    start_load();
    feed(0, 1, 0, 0, 0);
    bus.in_valid = 1'b0;
    repeat (254) tick();
    total++;
    if (key_err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early got e=%b busy=%b exp 0 1", key_err, busy);
    end
    tick();
    total++;
    if (key_err !== 1'b1 || busy !== 1'b0 || key_valid !== 1'b0 || key_x !== 30'h0) begin
      bad++;
      $display("FAIL timeout_fire got e=%b busy=%b v=%b x=%h exp 1 0 0 0", key_err, busy, key_valid, key_x);
    end
  endtask

  task automatic test_reload_backpressure();
    set_bytes({8'h02, 8'h78, 8'h56, 8'h34, 8'h12}, 8'hAF);
    start_load();
    feed(0, 5, 0, 0, 0);
    tick();
    set_bytes({8'h03, 8'h00, 8'hFF, 8'h00, 8'hFF}, 8'h00);
    fill_csum();
    start_load();
    total++;
    if (key_valid !== 1'b0 || key_p !== 4'h2 || key_x !== 30'h27856341) begin
      bad++;
      $display("FAIL reload_hold got v=%b p=%h x=%h exp 0 2 27856341", key_valid, key_p, key_x);
    end
    feed(0, 5, 0, 1, 0);
    total++;
    if (key_p !== 4'h2 || key_x !== 30'h27856341) begin
      bad++;
      $display("FAIL reload_no_mix got p=%h x=%h exp 2 27856341", key_p, key_x);
    end
    tick();
    total++;
    if (key_valid !== 1'b1 || key_p !== 4'hF || key_x !== 30'h300FF00F) begin
      bad++;
      $display("FAIL reload_commit got v=%b p=%h x=%h exp 1 f 300ff00f", key_valid, key_p, key_x);
    end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 5; i++) kb[i] = 8'($urandom);
    start_load();
    feed(0, 2, 1, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({key_p, key_x, key_valid, key_err, busy, bus.in_ready} !== 38'h0) begin
      bad++;
      $display("FAIL reset_mid_load got=%h exp=0", {key_p, key_x, key_valid, key_err, busy, bus.in_ready});
    end
    for (int i = 0; i < 5; i++) kb[i] = 8'($urandom);
    kb[4][7:2] = 6'd0;
    fill_csum();
    model_load();
    start_load();
    feed(0, 5, 2, 0, 0);
    tick();
    total++;
    if (key_valid !== 1'b1 || key_p !== exp_p || key_x !== exp_x) begin
      bad++;
      $display("FAIL reload_after_rst got v=%b p=%h x=%h exp 1 %h %h", key_valid, key_p, key_x, exp_p, exp_x);
    end
  endtask

  task automatic test_random();
    logic [3:0]  held_p;
    logic [29:0] held_x;
    for (int n = 0; n < 24; n++) begin
      int kind;
      held_p = key_p;
      held_x = key_x;
      for (int i = 0; i < 5; i++) kb[i] = 8'($urandom);
      kind = $urandom_range(0, 3);
      if (kind != 1) kb[4][7:2] = 6'd0;
      fill_csum();
      if (kind == 2) kb[5] = kb[5] ^ (8'd1 << $urandom_range(0, 7));
      model_load();
      start_load();
      total++;
      if (key_valid !== 1'b0 || key_err !== 1'b0 || busy !== 1'b1 || key_p !== held_p || key_x !== held_x) begin
        bad++;
        $display("FAIL rand_start[%0d] v=%b e=%b busy=%b p=%h x=%h exp 0 0 1 %h %h",
                 n, key_valid, key_err, busy, key_p, key_x, held_p, held_x);
      end
      feed(0, 5, 4, 0, 1);
      tick();
      total++;
      if (key_valid !== exp_ok || key_err !== !exp_ok || key_p !== exp_p || key_x !== exp_x) begin
        bad++;
        $display("FAIL rand_commit[%0d] v=%b e=%b p=%h x=%h exp %b %b %h %h",
                 n, key_valid, key_err, key_p, key_x, exp_ok, !exp_ok, exp_p, exp_x);
      end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_reserved();
    test_timeout();
    test_reload_backpressure();
    test_reset_mid_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
